// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit:
// FSM states, opcode/funct constants and datapath select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLT   = 6'b000110;
  localparam logic [5:0] OP_BLE   = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MOV = 6'b110000;
  localparam logic [5:0] FN_NOT = 6'b110001;

  localparam logic [2:0] ALU_MOV = 3'b000;
  localparam logic [2:0] ALU_NOT = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] BORN_BEQ = 2'b00;
  localparam logic [1:0] BORN_BNE = 2'b01;
  localparam logic [1:0] BORN_BLT = 2'b10;
  localparam logic [1:0] BORN_BLE = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  function automatic logic op_legal(input logic [5:0] op);
    op_legal = (op == OP_RTYPE) || (op == OP_LW)
            || (op == OP_SW)    || (op == OP_ADDI)
            || (op == OP_BEQ)   || (op == OP_BNE)
            || (op == OP_BLT)   || (op == OP_BLE)
            || (op == OP_J);
  endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// Control <-> datapath bundle: IR fields and Flag in,
// all mux selects, enables, ALU codes and debug State out.
interface multi_cycle_control_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Flag;
  logic       PCEn;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       SwapAB;
  logic [2:0] ALUControl;
  logic [1:0] BorN;
  logic [1:0] PCSource;
  logic       InstrDone;
  logic       IllegalOp;
  logic [3:0] State;

  modport master (
    input  Opcode, Funct, Flag,
    output PCEn, IorD, MemRead, MemWrite,
    output IRWrite, RegDst, MemtoReg,
    output RegWrite, ALUSrcA, ALUSrcB,
    output SwapAB, ALUControl, BorN,
    output PCSource, InstrDone, IllegalOp,
    output State
  );

  modport slave (
    output Opcode, Funct, Flag,
    input  PCEn, IorD, MemRead, MemWrite,
    input  IRWrite, RegDst, MemtoReg,
    input  RegWrite, ALUSrcA, ALUSrcB,
    input  SwapAB, ALUControl, BorN,
    input  PCSource, InstrDone, IllegalOp,
    input  State
  );
endinterface

// File: rtl/alu_decoder.sv
// R-type funct decoder: funct_i -> ALU opcode, operand swap,
// and valid flag (0 for an unknown funct).
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctl_o,
  output logic       swap_o,
  output logic       valid_o
);

  always_comb begin
    alu_ctl_o = ALU_ADD;
    swap_o    = 1'b0;
    valid_o   = 1'b1;
    unique case (funct_i)
      FN_ADD: alu_ctl_o = ALU_ADD;
      // ALU computes B-A, so rs-rt needs A/B swapped
      FN_SUB: begin
        alu_ctl_o = ALU_SUB;
        swap_o    = 1'b1;
      end
      FN_AND: alu_ctl_o = ALU_AND;
      FN_OR:  alu_ctl_o = ALU_OR;
      FN_XOR: alu_ctl_o = ALU_XOR;
      FN_SLT: alu_ctl_o = ALU_SLT;
      FN_MOV: alu_ctl_o = ALU_MOV;
      FN_NOT: alu_ctl_o = ALU_NOT;
      default: valid_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS main control FSM. Ports: Clk, Reset (async,
// active-low) and the master side of multi_cycle_control_if.
module multi_cycle_control
  import mips_ctrl_pkg::*;
(
  input logic                   Clk,
  input logic                   Reset,
  multi_cycle_control_if.master bus
);

  state_t     state_q;
  logic [2:0] aluc_q;
  logic       swap_q;

  logic [2:0] dec_alu;
  logic       dec_swap;
  logic       dec_valid;

  alu_decoder u_dec (
    .funct_i   (bus.Funct),
    .alu_ctl_o (dec_alu),
    .swap_o    (dec_swap),
    .valid_o   (dec_valid)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_FETCH;
      aluc_q  <= ALU_ADD;
      swap_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          unique case (bus.Opcode)
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_RTYPE:     state_q <= S_EXEC;
            OP_ADDI:      state_q <= S_ADDIEX;
            OP_BEQ, OP_BNE,
            OP_BLT, OP_BLE: state_q <= S_BRANCH;
            OP_J:         state_q <= S_JUMP;
            default:      state_q <= S_FETCH;
          endcase
        end
        S_MEMADR: state_q <= (bus.Opcode == OP_SW)
                           ? S_MEMWR : S_MEMRD;
        S_MEMRD:  state_q <= S_MEMWB;
        S_EXEC: begin
          // hold the decode for the writeback cycle
          aluc_q  <= dec_alu;
          swap_q  <= dec_swap;
          state_q <= dec_valid ? S_ALUWB : S_FETCH;
        end
        S_ADDIEX: state_q <= S_ADDIWB;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  logic       pcwrite, branch, iord, memread;
  logic       memwrite, irwrite, regdst, memtoreg;
  logic       regwrite, srca, swap, done, illegal;
  logic [1:0] srcb, born, pcsrc;
  logic [2:0] aluc;

  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    iord     = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    srca     = 1'b0;
    swap     = 1'b0;
    done     = 1'b0;
    illegal  = 1'b0;
    srcb     = SRCB_REG;
    born     = BORN_BEQ;
    pcsrc    = PCS_ALU;
    aluc     = ALU_ADD;
    unique case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        irwrite = 1'b1;
        pcwrite = 1'b1;
        srcb    = SRCB_FOUR;
      end
      S_DECODE: begin
        srcb    = SRCB_IMM2;
        illegal = !op_legal(bus.Opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        srca = 1'b1;
        srcb = SRCB_IMM;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        done     = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        done     = 1'b1;
      end
      S_EXEC: begin
        srca    = 1'b1;
        aluc    = dec_alu;
        swap    = dec_swap;
        illegal = !dec_valid;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        done     = 1'b1;
        aluc     = aluc_q;
        swap     = swap_q;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        done     = 1'b1;
      end
      S_BRANCH: begin
        srca   = 1'b1;
        branch = 1'b1;
        pcsrc  = PCS_ALUOUT;
        born   = bus.Opcode[1:0];
        aluc   = ALU_SUB;
        done   = 1'b1;
      end
      S_JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = PCS_JUMP;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  // every output is held low while Reset is asserted
  assign bus.PCEn       = Reset
                        & (pcwrite | (branch & bus.Flag));
  assign bus.IorD       = Reset & iord;
  assign bus.MemRead    = Reset & memread;
  assign bus.MemWrite   = Reset & memwrite;
  assign bus.IRWrite    = Reset & irwrite;
  assign bus.RegDst     = Reset & regdst;
  assign bus.MemtoReg   = Reset & memtoreg;
  assign bus.RegWrite   = Reset & regwrite;
  assign bus.ALUSrcA    = Reset & srca;
  assign bus.ALUSrcB    = Reset ? srcb : 2'b00;
  assign bus.SwapAB     = Reset & swap;
  assign bus.ALUControl = Reset ? aluc : 3'b000;
  assign bus.BorN       = Reset ? born : 2'b00;
  assign bus.PCSource   = Reset ? pcsrc : 2'b00;
  assign bus.InstrDone  = Reset & done;
  assign bus.IllegalOp  = Reset & illegal;
  assign bus.State      = Reset ? state_q : 4'd0;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: walks each
// instruction class and checks state and control outputs.
module tb_multi_cycle_control;

  logic Clk;
  logic Reset;
  int   errs;
  int   checks;
  int   done_cnt;

  multi_cycle_control_if bus ();

  multi_cycle_control dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [20:0] outs;
  assign outs = {bus.PCEn, bus.IorD, bus.MemRead,
                 bus.MemWrite, bus.IRWrite, bus.RegDst,
                 bus.MemtoReg, bus.RegWrite, bus.ALUSrcA,
                 bus.ALUSrcB, bus.SwapAB, bus.ALUControl,
                 bus.BorN, bus.PCSource, bus.InstrDone,
                 bus.IllegalOp};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge Clk);
  endtask

  initial begin
    int lw_st[5];
    lw_st = '{0, 1, 2, 3, 4};
    errs       = 0;
    checks     = 0;
    done_cnt   = 0;
    Reset      = 1'b0;
    bus.Opcode = 6'b100011;
    bus.Funct  = 6'b000000;
    bus.Flag   = 1'b0;

    repeat (2) cyc();
    chk("rst_outs", 32'(outs), 0);
    chk("rst_state", 32'(bus.State), 0);
    Reset = 1'b1;
    #1;
    chk("rel_state", 32'(bus.State), 0);
    chk("rel_memrd", 32'(bus.MemRead), 1);
    chk("fetch_srcb", 32'(bus.ALUSrcB), 1);
    chk("fetch_pcen", 32'(bus.PCEn), 1);

    // LW: 0,1,2,3,4 then back to FETCH
    for (int i = 0; i < 5; i++) begin
      chk("lw_state", 32'(bus.State), 32'(lw_st[i]));
      chk("lw_regwr", 32'(bus.RegWrite), 32'(i == 4));
      chk("lw_m2r", 32'(bus.MemtoReg), 32'(i == 4));
      done_cnt += int'(bus.InstrDone);
      cyc();
    end
    chk("lw_end", 32'(bus.State), 0);
    chk("lw_done", 32'(done_cnt), 1);

    // reset mid-MEMRD
    repeat (3) cyc();
    chk("memrd_state", 32'(bus.State), 3);
    Reset = 1'b0;
    #1;
    chk("mrst_outs", 32'(outs), 0);
    chk("mrst_state", 32'(bus.State), 0);
    cyc();
    chk("mrst_outs2", 32'(outs), 0);
    Reset = 1'b1;
    #1;
    chk("mrel_state", 32'(bus.State), 0);
    chk("mrel_memrd", 32'(bus.MemRead), 1);

    // R-type SUB
    bus.Opcode = 6'b000000;
    bus.Funct  = 6'b100010;
    repeat (2) cyc();
    chk("sub_state", 32'(bus.State), 6);
    chk("sub_alu", 32'(bus.ALUControl), 3);
    chk("sub_swap", 32'(bus.SwapAB), 1);
    chk("sub_srca", 32'(bus.ALUSrcA), 1);
    chk("sub_srcb", 32'(bus.ALUSrcB), 0);
    cyc();
    chk("subwb_state", 32'(bus.State), 7);
    chk("subwb_dst", 32'(bus.RegDst), 1);
    chk("subwb_wr", 32'(bus.RegWrite), 1);
    chk("subwb_alu", 32'(bus.ALUControl), 3);
    chk("subwb_done", 32'(bus.InstrDone), 1);
    cyc();
    chk("sub_end", 32'(bus.State), 0);

    // R-type XOR
    bus.Funct = 6'b100110;
    repeat (2) cyc();
    chk("xor_alu", 32'(bus.ALUControl), 6);
    chk("xor_swap", 32'(bus.SwapAB), 0);
    cyc();
    chk("xorwb_state", 32'(bus.State), 7);
    chk("xorwb_alu", 32'(bus.ALUControl), 6);
    cyc();

    // unknown funct: EXEC -> FETCH, no writeback
    bus.Funct = 6'b111111;
    repeat (2) cyc();
    chk("badfn_state", 32'(bus.State), 6);
    chk("badfn_ill", 32'(bus.IllegalOp), 1);
    cyc();
    chk("badfn_next", 32'(bus.State), 0);
    chk("badfn_wr", 32'(bus.RegWrite), 0);

    // BLT taken then not taken
    bus.Opcode = 6'b000110;
    bus.Flag   = 1'b1;
    repeat (2) cyc();
    chk("blt_state", 32'(bus.State), 8);
    chk("blt_born", 32'(bus.BorN), 2);
    chk("blt_pcen1", 32'(bus.PCEn), 1);
    chk("blt_pcsrc", 32'(bus.PCSource), 1);
    chk("blt_alu", 32'(bus.ALUControl), 3);
    bus.Flag = 1'b0;
    #1;
    chk("blt_pcen0", 32'(bus.PCEn), 0);
    cyc();
    chk("blt_end", 32'(bus.State), 0);

    // illegal opcode
    bus.Opcode = 6'b111111;
    cyc();
    chk("ill_state", 32'(bus.State), 1);
    chk("ill_pulse", 32'(bus.IllegalOp), 1);
    chk("ill_rw", 32'({bus.RegWrite, bus.MemWrite}), 0);
    cyc();
    chk("ill_next", 32'(bus.State), 0);
    chk("ill_clr", 32'(bus.IllegalOp), 0);

    // J
    bus.Opcode = 6'b000010;
    cyc();
    chk("j_dec", 32'(bus.State), 1);
    cyc();
    chk("j_state", 32'(bus.State), 11);
    chk("j_pcsrc", 32'(bus.PCSource), 2);
    chk("j_pcen", 32'(bus.PCEn), 1);
    chk("j_done", 32'(bus.InstrDone), 1);
    cyc();
    chk("j_end", 32'(bus.State), 0);

    // ADDI
    bus.Opcode = 6'b001000;
    repeat (2) cyc();
    chk("addi_state", 32'(bus.State), 9);
    chk("addi_srcb", 32'(bus.ALUSrcB), 2);
    cyc();
    chk("addiwb_state", 32'(bus.State), 10);
    chk("addiwb_dst", 32'({bus.RegWrite, bus.RegDst}), 2);
    cyc();

    // SW
    bus.Opcode = 6'b101011;
    repeat (3) cyc();
    chk("sw_state", 32'(bus.State), 5);
    chk("sw_wr", 32'({bus.MemWrite, bus.IorD}), 3);
    cyc();
    chk("sw_end", 32'(bus.State), 0);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
